// File: rtl/alu_pkg.sv
// Shared ALU definitions: action codes used by ALU control and the EX stage,
// plus the execute FSM state type.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } exec_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Keeps the low DATA_W bits of the unsigned product.
module alu_seq_mul #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] product_o,
   output logic              last_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start_i) begin
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (abort_i) begin
         cnt_d  = '0;
         busy_d = 1'b0;
      end else if (busy_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_ONE;
         if (cnt_q == LAST_CNT) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign product_o = acc_q;
   assign last_o    = busy_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result/flags and valid/ready handshake.
// Define ALU_EXEC_MUL_EN to build the iterative multiply (code 1000).
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_action,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              overflow,
   output logic              illegal
);

   localparam int              MSB = DATA_W - 1;
   localparam logic [MSB:0]    ONE = DATA_W'(1);

   logic [MSB:0] sum, b_neg, diff, res_d;
   logic         ovf_d, ill_d;
   logic         can_load, accept;

   logic [MSB:0] result_q;
   logic         out_valid_q, zero_q, ovf_q, ill_q;

   assign sum      = op_a + op_b;
   assign b_neg    = ~op_b + ONE;
   assign diff     = op_a + b_neg;
   assign can_load = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      ill_d = 1'b0;
      unique case (alu_action)
         ALU_AND: res_d = op_a & op_b;
         ALU_OR:  res_d = op_a | op_b;
         ALU_ADD: begin
            res_d = sum;
            ovf_d = (op_a[MSB] == op_b[MSB]) &&
                    (sum[MSB] != op_a[MSB]);
         end
         ALU_SUB: begin
            res_d = diff;
            ovf_d = (op_a[MSB] == b_neg[MSB]) &&
                    (diff[MSB] != op_a[MSB]);
         end
         ALU_SLT: res_d = {{(DATA_W-1){1'b0}},
                           $signed(op_a) < $signed(op_b)};
`ifdef ALU_EXEC_MUL_EN
         ALU_MUL: ;
`endif
         default: ill_d = 1'b1;
      endcase
   end

`ifdef ALU_EXEC_MUL_EN
   exec_state_t  state_q;
   logic         mul_start, mul_last;
   logic [MSB:0] product;

   assign in_ready  = rst_n && (state_q == IDLE) && can_load;
   assign mul_start = accept && (alu_action == ALU_MUL);

   alu_seq_mul #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .abort_i   (flush),
      .a_i       (op_a),
      .b_i       (op_b),
      .product_o (product),
      .last_o    (mul_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else if (flush) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         // Retire first; a load below in the same edge overrides it.
         if (out_ready) out_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (mul_start) begin
                  state_q <= MUL;
               end else if (accept) begin
                  result_q    <= res_d;
                  zero_q      <= (res_d == '0);
                  ovf_q       <= ovf_d;
                  ill_q       <= ill_d;
                  out_valid_q <= 1'b1;
               end
            end
            MUL: begin
               if (mul_last) state_q <= DONE;
            end
            DONE: begin
               if (can_load) begin
                  result_q    <= product;
                  zero_q      <= (product == '0);
                  ovf_q       <= 1'b0;
                  ill_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
`else
   assign in_ready = rst_n && can_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else begin
         if (out_ready) out_valid_q <= 1'b0;
         if (accept) begin
            result_q    <= res_d;
            zero_q      <= (res_d == '0);
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
            out_valid_q <= 1'b1;
         end
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign illegal   = ill_q;

endmodule
